// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing one registered-read FIFO port between NUM_REQ consumers.
// Each grant issues a burst of up to BURST_LEN reads, then a one-cycle drain for the last word.
module fifo_read_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [NUM_REQ-1:0] valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               busy_o,
    output logic               fifo_rd_en_o,
    input  logic               fifo_empty_i,
    input  logic [WIDTH-1:0]   fifo_data_i
);

    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(BURST_LEN + 1);
    localparam logic [OW-1:0] LastReq  = OW'(NUM_REQ - 1);
    localparam logic [CW-1:0] BurstMax = CW'(BURST_LEN);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

    state_e             state_q, state_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] valid_q, valid_d;

    logic               pick_found;
    logic [OW-1:0]      pick_idx;
    logic [OW-1:0]      cand;
    logic               owner_req;
    logic               rd_en;

    assign owner_req = req_i[owner_q];

    // First requester at or after ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = OW'((int'(ptr_q) + i) % int'(NUM_REQ));
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        valid_d = '0;
        if (rd_en) begin
            valid_d[owner_q] = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (rd_en) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!owner_req) begin
                    state_d = StDrain;
                end else if (rd_en && (cnt_q + CW'(1) == BurstMax)) begin
                    state_d = StDrain;
                end else if (fifo_empty_i && (cnt_q != '0)) begin
                    // An empty FIFO before the first read keeps waiting instead.
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StIdle;
                ptr_d   = (owner_q == LastReq) ? '0 : owner_q + OW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_o  = '0;
        busy_o = (state_q != StIdle);
        rd_en  = (state_q == StBurst) && owner_req && !fifo_empty_i && (cnt_q < BurstMax);
        if (state_q != StIdle) begin
            gnt_o[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign valid_o      = valid_q;
    assign data_o       = fifo_data_i;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: cycle table for a two-burst run, scoreboarded data delivery,
// and directed sequences for empty-wait, early release, mid-burst reset and 3-way pointer wrap.
module tb_fifo_read_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] req, gnt, valid;
    logic [7:0] data, fifo_data;
    logic       busy, rd_en, fifo_empty;

    logic [2:0] req3, gnt3, valid3;
    logic [7:0] data3;
    logic       busy3, rd_en3;
    logic [7:0] fifo_data3;
    logic       fifo_empty3;
    assign fifo_data3  = 8'h5A;
    assign fifo_empty3 = 1'b0;

    fifo_read_arbiter #(.NUM_REQ(2), .WIDTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .valid_o(valid), .data_o(data),
        .busy_o(busy), .fifo_rd_en_o(rd_en), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data)
    );

    fifo_read_arbiter #(.NUM_REQ(3), .WIDTH(8), .BURST_LEN(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .gnt_o(gnt3), .valid_o(valid3), .data_o(data3),
        .busy_o(busy3), .fifo_rd_en_o(rd_en3), .fifo_empty_i(fifo_empty3),
        .fifo_data_i(fifo_data3)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic       busy;
        logic       rd_en;
        logic [1:0] valid;
    } vec_t;

    typedef struct {
        int         cons;
        logic [7:0] data;
    } exp_t;

    vec_t       vecs[17];
    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [2:0] g3[$];
    int         v3_cnt, r3_cnt;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, want, $time);
    endtask

    task automatic push_word(input logic [7:0] d, input int cons);
        exp_t e;
        e.cons = cons;
        e.data = d;
        fifo_q.push_back(d);
        exp_q.push_back(e);
        fifo_empty <= 1'b0;
    endtask

    // Registered-read FIFO model.
    task automatic fifo_model();
        forever begin
            @(posedge clk);
            if (rd_en && fifo_q.size() != 0) begin
                fifo_data  <= fifo_q.pop_front();
                fifo_empty <= (fifo_q.size() == 0);
            end
        end
    endtask

    task automatic monitor();
        exp_t       e;
        logic [1:0] oh;
        forever begin
            @(negedge clk);
            if (valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_valid: got valid_o=%b data_o=%h, required none at %0t",
                             valid, data, $time);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 2'b01 << e.cons;
                    check("valid_owner", 32'(valid), 32'(oh));
                    check("data", 32'(data), 32'(e.data));
                end
            end
            if (rd_en) check("no_read_when_empty", 32'(fifo_empty), 32'h0);
        end
    endtask

    task automatic grant_rec();
        logic [2:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            if (gnt3 != 3'b000 && prev == 3'b000) g3.push_back(gnt3);
            if (valid3 != 3'b000) v3_cnt++;
            if (rd_en3) r3_cnt++;
            prev = gnt3;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        req3  = 3'b000;
        fifo_q.delete();
        exp_q.delete();
        g3.delete();
        v3_cnt = 0;
        r3_cnt = 0;
        fifo_empty <= 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_reads(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 50 && seen < n; i++) begin
            @(negedge clk);
            if (rd_en) seen++;
        end
        check(name, 32'(seen), 32'(n));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (busy && i < 50);
        check(name, 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        req3  = 3'b000;
        v3_cnt = 0;
        r3_cnt = 0;
        fifo_empty <= 1'b1;
        fifo_data  <= 8'h00;
        fork
            monitor();
            fifo_model();
            grant_rec();
        join_none

        // {req, gnt, busy, rd_en, valid} per cycle; FIFO preloaded with six words.
        vecs[0]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[1]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b00};
        vecs[2]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01};
        vecs[3]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01};
        vecs[4]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01};
        vecs[5]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b01};
        vecs[6]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[7]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b00};
        vecs[8]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01};
        vecs[9]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b01};
        vecs[10] = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b00};
        vecs[11] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[12] = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b00};
        vecs[13] = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b00};
        vecs[14] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b00};
        vecs[15] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b00};
        vecs[16] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00};

        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_rd_en", 32'(rd_en), 32'h0);
        check("reset_gnt3", 32'(gnt3), 32'h0);

        // T1: single requester, six words: one full burst, then a short one ending on empty.
        do_reset();
        for (int j = 0; j < 6; j++) push_word(8'(8'hA0 + j), 0);
        for (int i = 0; i < 17; i++) begin
            req = vecs[i].req;
            @(negedge clk);
            check($sformatf("t1_gnt[%0d]", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("t1_rd_en[%0d]", i), 32'(rd_en), 32'(vecs[i].rd_en));
            check($sformatf("t1_valid[%0d]", i), 32'(valid), 32'(vecs[i].valid));
            @(posedge clk);
            #1;
        end
        wait_drain("t1_drain");

        // T2: both requesting, grants alternate with four words each.
        do_reset();
        for (int j = 0; j < 16; j++) push_word(8'(8'h10 + j), (j / 4) % 2);
        req = 2'b11;
        wait_drain("t2_drain");
        req = 2'b00;
        wait_idle("t2_idle");

        // T3: grant on an empty FIFO waits without reading until a word arrives.
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_no_read", 32'(rd_en), 32'h0);
        end
        check("t3_gnt", 32'(gnt), 32'h1);
        check("t3_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1 push_word(8'h3C, 0);
        @(negedge clk);
        check("t3_rd_en", 32'(rd_en), 32'h1);
        wait_drain("t3_drain");
        req = 2'b00;
        wait_idle("t3_idle");

        // T4: req0 releases after two reads; pointer moves on so req1 wins a tie.
        do_reset();
        push_word(8'h40, 0);
        push_word(8'h41, 0);
        push_word(8'h42, 1);
        push_word(8'h43, 1);
        req = 2'b01;
        wait_reads(2, "t4_two_reads");
        @(posedge clk);
        #1 req = 2'b00;
        wait_idle("t4_idle");
        check("t4_req0_pulses", 32'(exp_q.size()), 32'h2);
        req = 2'b11;
        @(negedge clk);
        check("t4_next_gnt", 32'(gnt), 32'h2);
        wait_drain("t4_drain");
        req = 2'b00;
        wait_idle("t4_idle2");

        // T5: reset mid-burst kills the pending word; req1 then gets a clean grant.
        do_reset();
        for (int j = 0; j < 4; j++) push_word(8'(8'h50 + j), 0);
        req = 2'b01;
        wait_reads(2, "t5_two_reads");
        @(posedge clk);
        #1 rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty <= 1'b1;
        #1;
        check("t5_gnt", 32'(gnt), 32'h0);
        check("t5_valid", 32'(valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_rd_en", 32'(rd_en), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_word(8'h60, 1);
        push_word(8'h61, 1);
        req = 2'b10;
        @(negedge clk);
        @(negedge clk);
        check("t5_gnt_req1", 32'(gnt), 32'h2);
        wait_drain("t5_drain");
        req = 2'b00;
        wait_idle("t5_idle");

        // T6: three requesters, 0 and 2 held: grants alternate and never reach req1.
        do_reset();
        req3 = 3'b101;
        repeat (40) @(posedge clk);
        #1 req3 = 3'b000;
        repeat (10) @(posedge clk);
        #1;
        check("t6_grant_count", 32'(g3.size() >= 6), 32'h1);
        for (int i = 0; i < g3.size(); i++)
            check($sformatf("t6_order[%0d]", i), 32'(g3[i]), (i % 2 == 0) ? 32'h1 : 32'h4);
        check("t6_valid_vs_reads", 32'(v3_cnt), 32'(r3_cnt));
        check("t6_data", 32'(data3), 32'h5A);
        check("t6_idle", 32'(busy3), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
